npc_lsu: RTL and testbench
==========================

Name: npc_lsu

Overview:
Multi-cycle load/store unit for the next-generation NPC core. It replaces the combinational DPI memory access with a valid/ready handshake on three sides: the execute stage, a memory bus and writeback.
- Parametrised in data width (RV32/RV64) and number of byte lanes.
- Performs byte-lane alignment, write-mask generation, load sign/zero extension and misalignment checking.
- Sits between EXU and WBU; the core stalls on in_ready/out_valid.

Parameters:
XLEN, 32, data/register width; legal values 32 or 64
ADDR_W, 32, address width
NB, XLEN/8, byte lanes per bus beat; derived, not overridable
TIMEOUT, 255, cycles to wait for mem_rsp_valid before an error response (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  EXU presents an access
in_ready  out  1  LSU can accept an access (IDLE only)
in_store  in  1  1 = store, 0 = load
in_funct3  in  3  RISC-V funct3 size/sign code
in_addr  in  ADDR_W  effective address (rs1+imm)
in_wdata  in  XLEN  store data (rs2), unshifted
in_rd  in  5  load destination register
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_wen  out  1  write request
mem_req_addr  out  ADDR_W  beat-aligned address (low log2(NB) bits zero)
mem_req_wdata  out  XLEN  lane-shifted store data
mem_req_wmask  out  NB  byte write enables
mem_rsp_valid  in  1  bus response (loads and stores)
mem_rsp_rdata  in  XLEN  full-beat read data
mem_rsp_err  in  1  bus error
out_valid  out  1  result available to WBU
out_ready  in  1  WBU consumes result
out_rdata  out  XLEN  extended load data; 0 for stores
out_rd  out  5  destination register; 0 for stores
out_err  out  1  access faulted (misaligned, bus error or timeout)

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset (reset low, asynchronous): state = IDLE. in_ready=1. mem_req_valid=0, out_valid=0. All data outputs, out_err, mem_req_wen and mem_req_wmask are 0.
- Reset mid-operation aborts the access and issues no further bus traffic. A later bus response is ignored because the FSM is in IDLE with no request pending.
- IDLE: in_ready=1. On in_valid, all inputs are latched and the access is checked.
  - Size by funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
  - XLEN=64 adds 011 d and 110 wu.
  - Any other code is illegal; treat it as misaligned (out_err).
- Misaligned means addr is not a multiple of the access size. A misaligned access goes IDLE->RESP, issues no bus request, and sets out_err=1, out_rdata=0.
- A legal access goes IDLE->REQ.
- REQ: mem_req_valid=1 and all request fields are held stable until mem_req_ready. The request fields are:
  - off = addr[log2(NB)-1:0]
  - mem_req_addr = addr with the off bits cleared
  - mem_req_wmask = ((1<<size)-1)<<off for stores, 0 for loads
  - mem_req_wdata = wdata<<(8*off)
  - On mem_req_ready: REQ->WAIT.
- WAIT: a mem_rsp_valid arriving in the same cycle as the request handshake is not sampled; the response is sampled from the following cycle onward. On mem_rsp_valid: WAIT->RESP.
  - Loads: out_rdata = (rdata>>(8*off)) truncated to size, sign-extended for b/h/w and zero-extended for bu/hu/wu.
  - out_err = mem_rsp_err. If mem_rsp_err=1, out_rdata=0.
- RESP: out_valid=1 with out_rd/out_rdata/out_err held until out_ready, then RESP->IDLE. A new access can be accepted the cycle after the out handshake.
- Latency, with the input handshake at cycle T:
  - mem_req_valid at T+1.
  - With zero wait on the bus, response sampled at T+2 and out_valid at T+3.
  - Misaligned: out_valid at T+1.
- Only one access is ever outstanding.
- Stores complete only on mem_rsp_valid (write acknowledge). out_rd=0 for stores so the WBU performs no register write.

Optional Feature:
NPC_LSU_TIMEOUT_EN
- Defined: an 8..16-bit counter clears on entering WAIT and increments each WAIT cycle. Reaching TIMEOUT forces WAIT->RESP with out_err=1, out_rdata=0. A late response after that point is dropped while in IDLE.
- Undefined: no counter; WAIT waits indefinitely.

Decomposition:
- Package npc_lsu_pkg:
  - state enum: IDLE, REQ, WAIT, RESP
  - funct3 size constants: LSU_B, LSU_H, LSU_W, LSU_D, LSU_BU, LSU_HU, LSU_WU
  - function size_bytes(funct3)
- One sub-module, npc_lsu_align (combinational). It computes wmask/wdata shift for stores and load extraction/extension from (funct3, off, data). Both store and load paths instantiate it, so it can be unit-tested alone.

Test Plan:
- XLEN=32, sw 0xDEADBEEF @0x80000004, zero-wait bus -> req addr 0x80000004, wmask 0xF, wdata 0xDEADBEEF; out_valid at T+3, out_err=0, out_rd=0.
- sb 0x000000AB @0x80000003 -> wmask 0x8, wdata 0xAB000000, req addr 0x80000000.
- lb @0x80000002 with rsp rdata 0x12F45678 -> out_rdata 0xFFFFFFF4. Same access as lbu -> 0x000000F4. lhu @0x80000002 -> 0x000012F4.
- lw @0x80000002 -> no mem_req_valid ever, out_valid at T+1, out_err=1.
- mem_req_ready held low 5 cycles, then out_ready held low 3 cycles -> request fields stable throughout, out_valid/out_rdata stable, in_ready=0 until the out handshake. Same test asserting reset low in WAIT -> all outputs return to reset values immediately.
- With NPC_LSU_TIMEOUT_EN and TIMEOUT=10, never respond -> out_valid with out_err=1 after 10 WAIT cycles. A late mem_rsp_valid is ignored and the next access completes normally.

Source files
------------

// File: rtl/npc_lsu_pkg.sv
// Shared definitions for the NPC load/store unit.
// FSM state codes, RISC-V funct3 size codes and the access-size decoder.
// No logic of its own; imported by npc_lsu and npc_lsu_align.
package npc_lsu_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;

  // Access size in bytes; 0 marks a code that is illegal for this XLEN.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3, input logic rv64);
    case (funct3)
      LSU_B, LSU_BU: size_bytes = 4'd1;
      LSU_H, LSU_HU: size_bytes = 4'd2;
      LSU_W:         size_bytes = 4'd4;
      LSU_D:         size_bytes = rv64 ? 4'd8 : 4'd0;
      LSU_WU:        size_bytes = rv64 ? 4'd4 : 4'd0;
      default:       size_bytes = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// Byte-lane alignment: store mask/data shift and load extract/extend.
// Purely combinational, zero latency.
// No handshake; outputs follow the inputs.
module npc_lsu_align
  import npc_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [2:0]      funct3,
  input  logic [OW-1:0]   off,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] ld_data,
  output logic [NB-1:0]   wmask,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  localparam logic [NB-1:0] ONE = NB'(1);

  logic [3:0]      size;
  logic [NB-1:0]   base_mask;
  logic [XLEN-1:0] sh;

  // A full-width access wraps 1<<NB to zero, so the subtraction still yields all ones.
  assign size      = size_bytes(funct3, XLEN == 64);
  assign base_mask = (ONE << size) - ONE;
  assign wmask     = base_mask << off;
  assign wdata     = st_data << {off, 3'b000};
  assign sh        = ld_data >> {off, 3'b000};

  always_comb begin
    rdata = '0;
    case (funct3)
      LSU_B:  rdata = XLEN'($signed(sh[7:0]));
      LSU_BU: rdata = XLEN'(sh[7:0]);
      LSU_H:  rdata = XLEN'($signed(sh[15:0]));
      LSU_HU: rdata = XLEN'(sh[15:0]);
      LSU_W:  rdata = XLEN'($signed(sh[31:0]));
      LSU_WU: rdata = XLEN'(sh[31:0]);
      LSU_D:  rdata = sh;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/npc_lsu.sv
// Multi-cycle LSU between EXU and WBU; optional WAIT timeout via NPC_LSU_TIMEOUT_EN.
// Latency: mem_req_valid at T+1, out_valid at T+3 on a zero-wait bus, T+1 if misaligned.
// Backpressure: in_ready only in IDLE; request held until mem_req_ready, result until out_ready.
module npc_lsu
  import npc_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [4:0]        in_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [NB-1:0]     mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  input  logic              mem_rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic [4:0]        out_rd,
  output logic              out_err
);

  logic [1:0]        state;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic [4:0]        rd_q;
  logic              err_q;

  logic [3:0]        size_in;
  logic              mis_in;
  logic [NB-1:0]     al_wmask;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rdata;
  logic              tmo_hit;

  assign size_in = size_bytes(in_funct3, XLEN == 64);
  assign mis_in  = (size_in == 4'd0) || ((in_addr[3:0] & (size_in - 4'd1)) != 4'd0);

  npc_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3  (funct3_q),
    .off     (addr_q[OW-1:0]),
    .st_data (wdata_q),
    .ld_data (mem_rsp_rdata),
    .wmask   (al_wmask),
    .wdata   (al_wdata),
    .rdata   (al_rdata)
  );

`ifdef NPC_LSU_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? 16 : 8;
  logic [TW-1:0] tmo_cnt;

  // Zero on every cycle outside WAIT, so it starts from zero on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_cnt <= '0;
    else if (state != WAIT) tmo_cnt <= '0;
    else tmo_cnt <= tmo_cnt + 1'b1;
  end
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          store_q  <= in_store;
          funct3_q <= in_funct3;
          addr_q   <= in_addr;
          wdata_q  <= in_wdata;
          rd_q     <= in_store ? 5'd0 : in_rd;
          rdata_q  <= '0;
          err_q    <= mis_in;
          state    <= mis_in ? RESP : REQ;
        end
        REQ: if (mem_req_ready) state <= WAIT;
        WAIT: begin
          if (mem_rsp_valid) begin
            err_q   <= mem_rsp_err;
            rdata_q <= (mem_rsp_err || store_q) ? '0 : al_rdata;
            state   <= RESP;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= RESP;
          end
        end
        RESP: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign mem_req_wen   = (state == REQ) && store_q;
  assign mem_req_addr  = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
  assign mem_req_wdata = al_wdata;
  assign mem_req_wmask = mem_req_wen ? al_wmask : '0;
  assign out_valid     = (state == RESP);
  assign out_rdata     = rdata_q;
  assign out_rd        = rd_q;
  assign out_err       = err_q;

endmodule

// File: tb/tb_npc_lsu.sv
// Randomized self-checking bench for npc_lsu (XLEN=32) against an arithmetic reference model.
module tb_npc_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_store, in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  npc_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_rd(out_rd), .out_err(out_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_req_valid"}, mem_req_valid, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_wen"}, mem_req_wen, 0);
    chk({tag, "_wmask"}, mem_req_wmask, 0);
    chk({tag, "_req_addr"}, mem_req_addr, 0);
    chk({tag, "_req_wdata"}, mem_req_wdata, 0);
    chk({tag, "_out_rdata"}, out_rdata, 0);
    chk({tag, "_out_rd"}, out_rd, 0);
    chk({tag, "_out_err"}, out_err, 0);
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // mode 0: normal, 1: reset while waiting for the response, 2: never respond (timeout)
  task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input logic [31:0] rdat, input bit rerr,
                           input int req_dly, input int rsp_dly, input int out_dly,
                           input bit early, input int mode);
    int sz, off;
    bit mis;
    logic [63:0] v, szmask;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_wmask;
    logic [4:0]  e_rd;
    bit e_err;

    sz  = size_of(f3);
    off = int'(a % 4);
    mis = (sz == 0) || ((a % sz) != 0);
    e_addr  = a - off;
    e_wmask = st ? 4'(((1 << sz) - 1) << off) : 4'd0;
    e_wdata = 32'(64'(wd) << (8 * off));
    e_rd    = st ? 5'd0 : rd;
    e_err   = mis ? 1'b1 : rerr;
    e_rdata = 32'd0;
    if (!mis && !st && !rerr) begin
      szmask = (64'd1 << (8 * sz)) - 64'd1;
      v = (64'(rdat) >> (8 * off)) & szmask;
      if (f3[2] == 1'b0 && v[8*sz-1]) v = v | ~szmask;
      e_rdata = v[31:0];
    end

    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1; in_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd; in_rd = rd;
    @(negedge clk);
    in_valid = 0; in_store = $urandom; in_funct3 = 3'($urandom);
    in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);

    if (mis) begin
      chk("mis_no_req", mem_req_valid, 0);
    end else begin
      for (int i = 0; i <= req_dly; i++) begin
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, e_addr);
        chk("req_wmask", mem_req_wmask, e_wmask);
        chk("req_wen", mem_req_wen, st);
        if (st) chk("req_wdata", mem_req_wdata, e_wdata);
        chk("req_in_ready", in_ready, 0);
        chk("req_out_valid", out_valid, 0);
        if (i == req_dly) begin
          mem_req_ready = 1;
          if (early) begin
            mem_rsp_valid = 1; mem_rsp_rdata = ~rdat; mem_rsp_err = 1;
          end
        end
        @(negedge clk);
      end
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0;
      chk("wait_req_dropped", mem_req_valid, 0);

      if (mode == 1) begin
        mem_rsp_valid = 0;
        reset = 0;
        #1;
        chk_reset_outputs("rst_wait");
        @(negedge clk);
        reset = 1;
        mem_rsp_valid = 1; mem_rsp_rdata = rdat;
        @(negedge clk);
        mem_rsp_valid = 0;
        chk("rst_late_rsp_out_valid", out_valid, 0);
        chk("rst_late_rsp_req_valid", mem_req_valid, 0);
        chk("rst_late_rsp_in_ready", in_ready, 1);
        return;
      end

      if (mode == 2) begin
        for (int i = 0; i < 10; i++) begin
          chk("tmo_waiting", out_valid, 0);
          @(negedge clk);
        end
        e_err = 1; e_rdata = 0;
      end else begin
        for (int i = 0; i < rsp_dly; i++) begin
          chk("wait_out_valid", out_valid, 0);
          @(negedge clk);
        end
        mem_rsp_valid = 1; mem_rsp_rdata = rdat; mem_rsp_err = rerr;
        @(negedge clk);
        mem_rsp_valid = 0; mem_rsp_err = 0; mem_rsp_rdata = $urandom;
      end
    end

    for (int i = 0; i <= out_dly; i++) begin
      chk("out_valid", out_valid, 1);
      chk("out_rdata", out_rdata, e_rdata);
      chk("out_rd", out_rd, e_rd);
      chk("out_err", out_err, e_err);
      chk("out_in_ready", in_ready, 0);
      chk("out_no_req", mem_req_valid, 0);
      if (i == out_dly) out_ready = 1;
      @(negedge clk);
    end
    out_ready = 0;
    chk("done_out_valid", out_valid, 0);
    chk("done_in_ready", in_ready, 1);
  endtask

  initial begin
    reset = 0;
    in_valid = 0; in_store = 0; in_funct3 = 0; in_addr = 0; in_wdata = 0; in_rd = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0; mem_rsp_err = 0;
    out_ready = 0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1;

    do_access(1, 3'b010, 32'h80000004, 32'hDEADBEEF, 5'd7, 32'h0, 0, 0, 0, 0, 0, 0);
    do_access(1, 3'b000, 32'h80000003, 32'h000000AB, 5'd3, 32'h0, 0, 0, 0, 0, 0, 0);
    do_access(0, 3'b000, 32'h80000002, 32'h0, 5'd5, 32'h12F45678, 0, 0, 0, 0, 0, 0);
    do_access(0, 3'b100, 32'h80000002, 32'h0, 5'd6, 32'h12F45678, 0, 0, 0, 0, 0, 0);
    do_access(0, 3'b101, 32'h80000002, 32'h0, 5'd8, 32'h12F45678, 0, 0, 0, 0, 0, 0);
    do_access(0, 3'b010, 32'h80000002, 32'h0, 5'd9, 32'h12F45678, 0, 0, 0, 0, 0, 0);
    do_access(0, 3'b001, 32'h80000006, 32'h0, 5'd1, 32'h8001BEEF, 0, 5, 2, 3, 1, 0);
    do_access(0, 3'b010, 32'h80000008, 32'h0, 5'd2, 32'hCAFEF00D, 1, 0, 0, 0, 0, 0);
    do_access(1, 3'b001, 32'h80000002, 32'h1234ABCD, 5'd4, 32'h0, 0, 5, 0, 3, 0, 0);
    do_access(0, 3'b010, 32'h80000010, 32'h0, 5'd11, 32'h11223344, 0, 5, 1, 0, 0, 1);
    do_access(0, 3'b010, 32'h80000010, 32'h0, 5'd11, 32'h11223344, 0, 0, 0, 0, 0, 0);

`ifdef NPC_LSU_TIMEOUT_EN
    do_access(0, 3'b010, 32'h80000020, 32'h0, 5'd12, 32'h55667788, 0, 0, 0, 0, 0, 2);
    @(negedge clk);
    mem_rsp_valid = 1; mem_rsp_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_rsp_valid = 0;
    chk("tmo_late_rsp_out_valid", out_valid, 0);
    chk("tmo_late_rsp_in_ready", in_ready, 1);
    do_access(0, 3'b000, 32'h80000021, 32'h0, 5'd13, 32'h0000AA00, 0, 0, 0, 0, 0, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                32'h80000000 | 32'($urandom_range(0, 255)), $urandom, 5'($urandom),
                $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
